// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the mem/wb stage (master) and memory (slave).
interface mem_wb_stage_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [XLEN-1:0]   mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: one op in flight, lane-aligned loads and stores,
// single-cycle register-file write pulse.
module mem_wb_stage #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  mem_wb_stage_if.master    mem,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              wb_done,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_t;

  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010, 3'b110: bad = |off[1:0];
      3'b011:         bad = |off;
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      2'b11:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [2:0] off,
                                                   input logic [2:0] f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  res = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'b011:  res = sh;
      3'b100:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  res = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  state_t            state_r, next_state_s;
  logic [4:0]        rd_r;
  logic              we_r, wr_r;
  logic [2:0]        f3_r, off_r;
  logic [XLEN-1:0]   alu_r;

  logic              req_valid_r, req_valid_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              wen_r, wen_s;
  logic [XLEN-1:0]   wdata_r, wdata_s;
  logic [7:0]        wmask_r, wmask_s;
  logic              rf_we_r, rf_we_s;
  logic [4:0]        rf_waddr_r, rf_waddr_s;
  logic [XLEN-1:0]   rf_wdata_r, rf_wdata_s;
  logic              wb_done_r, wb_done_s;
  logic              err_r, err_s;

  logic [2:0]        off_s;
  logic              is_mem_s, mis_s, accept_s;

  assign off_s    = ex_alu_result[2:0];
  assign is_mem_s = ex_mem_read | ex_mem_write;
  assign mis_s    = is_mem_s & misaligned(ex_funct3, off_s);
  assign accept_s = (state_r == IDLE) & ex_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ex_valid) begin
          next_state_s = (is_mem_s & ~mis_s) ? REQ : WB;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          next_state_s = WB;
        end else begin
          next_state_s = WAIT;
        end
      end
      WB:      next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered bus and write-back outputs.
  always_comb begin
    req_valid_s = 1'b0;
    addr_s      = {ADDR_W{1'b0}};
    wen_s       = 1'b0;
    wdata_s     = {XLEN{1'b0}};
    wmask_s     = 8'h00;
    rf_we_s     = 1'b0;
    rf_waddr_s  = 5'd0;
    rf_wdata_s  = {XLEN{1'b0}};
    wb_done_s   = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (ex_valid && mis_s) begin
          wb_done_s  = 1'b1;
          err_s      = 1'b1;
          rf_waddr_s = ex_rd;
          rf_wdata_s = ex_alu_result;
        end else if (ex_valid && is_mem_s) begin
          req_valid_s = 1'b1;
          addr_s      = {ex_alu_result[ADDR_W-1:3], 3'b000};
          wen_s       = ex_mem_write;
          if (ex_mem_write) begin
            wdata_s = ex_store_data << {off_s, 3'b000};
            wmask_s = size_mask(ex_funct3[1:0]) << off_s;
          end else begin
            wdata_s = {XLEN{1'b0}};
            wmask_s = 8'h00;
          end
        end else if (ex_valid) begin
          wb_done_s  = 1'b1;
          rf_we_s    = ex_reg_we & (ex_rd != 5'd0);
          rf_waddr_s = ex_rd;
          rf_wdata_s = ex_alu_result;
        end else begin
          wb_done_s = 1'b0;
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          req_valid_s = 1'b0;
        end else begin
          req_valid_s = 1'b1;
          addr_s      = addr_r;
          wen_s       = wen_r;
          wdata_s     = wdata_r;
          wmask_s     = wmask_r;
        end
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          wb_done_s  = 1'b1;
          rf_we_s    = we_r & (rd_r != 5'd0) & ~wr_r;
          rf_waddr_s = rd_r;
          rf_wdata_s = wr_r ? alu_r : load_extract(mem.mem_rdata, off_r, f3_r);
        end else begin
          wb_done_s = 1'b0;
        end
      end
      WB:      wb_done_s = 1'b0;
      default: wb_done_s = 1'b0;
    endcase
  end

  // Latched op fields, captured on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r  <= 5'd0;
      we_r  <= 1'b0;
      wr_r  <= 1'b0;
      f3_r  <= 3'd0;
      off_r <= 3'd0;
      alu_r <= {XLEN{1'b0}};
    end else if (accept_s) begin
      rd_r  <= ex_rd;
      we_r  <= ex_reg_we;
      wr_r  <= ex_mem_write;
      f3_r  <= ex_funct3;
      off_r <= off_s;
      alu_r <= ex_alu_result;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_r <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wen_r       <= 1'b0;
      wdata_r     <= {XLEN{1'b0}};
      wmask_r     <= 8'h00;
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= 5'd0;
      rf_wdata_r  <= {XLEN{1'b0}};
      wb_done_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      req_valid_r <= req_valid_s;
      addr_r      <= addr_s;
      wen_r       <= wen_s;
      wdata_r     <= wdata_s;
      wmask_r     <= wmask_s;
      rf_we_r     <= rf_we_s;
      rf_waddr_r  <= rf_waddr_s;
      rf_wdata_r  <= rf_wdata_s;
      wb_done_r   <= wb_done_s;
      err_r       <= err_s;
    end
  end

  assign ex_ready          = (state_r == IDLE);
  assign mem.mem_req_valid = req_valid_r;
  assign mem.mem_addr      = addr_r;
  assign mem.mem_wen       = wen_r;
  assign mem.mem_wdata     = wdata_r;
  assign mem.mem_wmask     = wmask_r;
  assign rf_we             = rf_we_r;
  assign rf_waddr          = rf_waddr_r;
  assign rf_wdata          = rf_wdata_r;
  assign wb_done           = wb_done_r;
  assign misalign_err      = err_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: expected write-backs are queued at issue and
// compared when wb_done pulses.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_done, misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        err;
  } wb_exp_t;

  wb_exp_t sb_q[$];

  localparam logic [63:0] RWORD = 64'h8001_2345_6789_ABCD;

  mem_wb_stage_if #(.XLEN(64), .ADDR_W(64)) bus ();

  mem_wb_stage #(.XLEN(64), .ADDR_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_we     (ex_reg_we),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .mem           (bus),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .wb_done       (wb_done),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                       input logic we, input logic rd_f, input logic wr_f, input logic [2:0] f3);
    chk("issue_ex_ready", ex_ready, 64'd1);
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_we     = we;
    ex_mem_read   = rd_f;
    ex_mem_write  = wr_f;
    ex_funct3     = f3;
    ex_valid      = 1'b1;
    step();
    ex_valid      = 1'b0;
  endtask

  // Serve one request: hold ready low for 'stall' cycles, then accept and respond.
  task automatic mem_xact(input string tag, input logic [63:0] addr, input logic wen,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          input logic [63:0] rdata, input int stall, input bit early);
    for (int i = 0; i <= stall; i++) begin
      chk({tag, "_req_valid"}, bus.mem_req_valid, 64'd1);
      chk({tag, "_addr"}, bus.mem_addr, addr);
      chk({tag, "_wen"}, bus.mem_wen, {63'd0, wen});
      if (wen) begin
        chk({tag, "_wdata"}, bus.mem_wdata, wdata);
        chk({tag, "_wmask"}, bus.mem_wmask, {56'd0, wmask});
      end
      chk({tag, "_ex_ready_busy"}, ex_ready, 64'd0);
      bus.mem_req_ready = (i == stall);
      bus.mem_rsp_valid = early && (i == stall);
      bus.mem_rdata     = rdata;
      step();
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    chk({tag, "_req_drop"}, bus.mem_req_valid, 64'd0);
    if (early) begin
      step();
      chk({tag, "_accept_cycle_rsp_ignored"}, wb_done, 64'd0);
    end
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
  endtask

  // Wait for wb_done, compare against the scoreboard head, then check the pulse ends.
  task automatic wait_wb(input string tag, input int exp_lat);
    int      lat;
    wb_exp_t e;
    lat = 0;
    while (wb_done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_wb_done"}, wb_done, 64'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_sb_nonempty"}, sb_q.size() > 0, 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_rf_we"}, rf_we, {63'd0, e.we});
      chk({tag, "_rf_waddr"}, rf_waddr, {59'd0, e.waddr});
      if (e.we) begin
        chk({tag, "_rf_wdata"}, rf_wdata, e.wdata);
      end
      chk({tag, "_misalign_err"}, misalign_err, {63'd0, e.err});
    end
    step();
    chk({tag, "_rf_we_pulse_end"}, rf_we, 64'd0);
    chk({tag, "_wb_done_pulse_end"}, wb_done, 64'd0);
    chk({tag, "_err_pulse_end"}, misalign_err, 64'd0);
    chk({tag, "_ex_ready_again"}, ex_ready, 64'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ex_ready"}, ex_ready, 64'd1);
    chk({tag, "_req_valid"}, bus.mem_req_valid, 64'd0);
    chk({tag, "_wen"}, bus.mem_wen, 64'd0);
    chk({tag, "_addr"}, bus.mem_addr, 64'd0);
    chk({tag, "_wdata"}, bus.mem_wdata, 64'd0);
    chk({tag, "_wmask"}, bus.mem_wmask, 64'd0);
    chk({tag, "_rf_we"}, rf_we, 64'd0);
    chk({tag, "_rf_waddr"}, rf_waddr, 64'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 64'd0);
    chk({tag, "_wb_done"}, wb_done, 64'd0);
    chk({tag, "_misalign_err"}, misalign_err, 64'd0);
  endtask

  initial begin
    rst               = 1'b1;
    ex_valid          = 1'b0;
    ex_alu_result     = 64'd0;
    ex_store_data     = 64'd0;
    ex_rd             = 5'd0;
    ex_reg_we         = 1'b0;
    ex_mem_read       = 1'b0;
    ex_mem_write      = 1'b0;
    ex_funct3         = 3'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 64'd0;
    step();
    step();
    rst = 1'b0;
    chk_all_zero("reset");

    // ALU op: write-back the cycle after accept, ready again the cycle after that.
    sb_q.push_back('{1'b1, 5'd5, 64'h1234, 1'b0});
    issue(64'h1234, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    chk("alu_ex_ready_in_wb", ex_ready, 64'd0);
    wait_wb("alu", 0);

    sb_q.push_back('{1'b0, 5'd0, 64'h55, 1'b0});
    issue(64'h55, 64'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    wait_wb("alu_rd0", 0);

    sb_q.push_back('{1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b0});
    issue(64'h1003, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
    mem_xact("lb", 64'h1000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_8000_0000, 0, 1'b0);
    wait_wb("lb", 0);

    sb_q.push_back('{1'b1, 5'd7, 64'h80, 1'b0});
    issue(64'h1003, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b100);
    mem_xact("lbu", 64'h1000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_8000_0000, 1, 1'b1);
    wait_wb("lbu", 0);

    sb_q.push_back('{1'b0, 5'd3, 64'd0, 1'b0});
    issue(64'h2006, 64'hABCD, 5'd3, 1'b1, 1'b0, 1'b1, 3'b001);
    mem_xact("sh", 64'h2000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0, 64'd0, 3, 1'b0);
    wait_wb("sh", 0);

    sb_q.push_back('{1'b0, 5'd4, 64'd0, 1'b1});
    issue(64'h1002, 64'd0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
    chk("lw_mis_no_req", bus.mem_req_valid, 64'd0);
    wait_wb("lw_mis", 0);
    chk("lw_mis_no_req_after", bus.mem_req_valid, 64'd0);

    sb_q.push_back('{1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_8001, 1'b0});
    issue(64'h5006, 64'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b001);
    mem_xact("lh", 64'h5000, 1'b0, 64'd0, 8'h00, RWORD, 0, 1'b0);
    wait_wb("lh", 0);

    sb_q.push_back('{1'b1, 5'd11, 64'h0000_0000_8001_2345, 1'b0});
    issue(64'h5004, 64'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b110);
    mem_xact("lwu", 64'h5000, 1'b0, 64'd0, 8'h00, RWORD, 0, 1'b0);
    wait_wb("lwu", 0);

    sb_q.push_back('{1'b1, 5'd11, 64'hFFFF_FFFF_8001_2345, 1'b0});
    issue(64'h5004, 64'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010);
    mem_xact("lw", 64'h5000, 1'b0, 64'd0, 8'h00, RWORD, 0, 1'b0);
    wait_wb("lw", 0);

    sb_q.push_back('{1'b1, 5'd12, RWORD, 1'b0});
    issue(64'h5008, 64'd0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b011);
    mem_xact("ld", 64'h5008, 1'b0, 64'd0, 8'h00, RWORD, 0, 1'b0);
    wait_wb("ld", 0);

    sb_q.push_back('{1'b0, 5'd13, 64'd0, 1'b0});
    issue(64'h6000, 64'h0123_4567_89AB_CDEF, 5'd13, 1'b0, 1'b0, 1'b1, 3'b011);
    mem_xact("sd", 64'h6000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1, 1'b0);
    wait_wb("sd", 0);

    sb_q.push_back('{1'b0, 5'd2, 64'd0, 1'b0});
    issue(64'h6005, 64'h1122_3344_5566_77EE, 5'd2, 1'b1, 1'b0, 1'b1, 3'b000);
    mem_xact("sb", 64'h6000, 1'b1, 64'h6677_EE00_0000_0000, 8'h20, 64'd0, 0, 1'b0);
    wait_wb("sb", 0);

    sb_q.push_back('{1'b0, 5'd14, 64'd0, 1'b1});
    issue(64'h7000, 64'd0, 5'd14, 1'b1, 1'b1, 1'b0, 3'b111);
    chk("f3_111_no_req", bus.mem_req_valid, 64'd0);
    wait_wb("f3_111", 0);

    // Reset while waiting for a load response; the late response must be dropped.
    issue(64'h4000, 64'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b011);
    chk("rst_load_req_valid", bus.mem_req_valid, 64'd1);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("rst_load_in_wait", bus.mem_req_valid, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("after_rst");
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = RWORD;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("stale_rsp_rf_we", rf_we, 64'd0);
    chk("stale_rsp_wb_done", wb_done, 64'd0);
    chk("stale_rsp_ex_ready", ex_ready, 64'd1);

    sb_q.push_back('{1'b1, 5'd31, 64'hDEAD_BEEF_0000_0001, 1'b0});
    issue(64'hDEAD_BEEF_0000_0001, 64'd0, 5'd31, 1'b1, 1'b0, 1'b0, 3'b000);
    wait_wb("alu_after_rst", 0);

    chk("sb_empty", sb_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and write-back stage between execute and the register file.
- Accepts one retired-from-execute op at a time, performs the load/store on a valid/ready data-memory bus, aligns and extends load data, and drives the register file write port as a one-cycle write pulse.
- ALU-only ops pass through to write-back in one cycle.

Parameters:
- XLEN, 64, register and data-bus width in bits (must be 64; byte-lane logic assumes 8 lanes).
- ADDR_W, 64, memory address width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  execute presents an op.
- ex_ready  output  1  stage can accept an op this cycle.
- ex_alu_result  input  XLEN  ALU result; memory address for loads/stores.
- ex_store_data  input  XLEN  rs2 value for stores.
- ex_rd  input  5  destination register.
- ex_reg_we  input  1  op writes rd.
- ex_mem_read  input  1  op is a load.
- ex_mem_write  input  1  op is a store (never both read and write).
- ex_funct3  input  3  access size/sign.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_addr  output  ADDR_W  address, 8-byte aligned (addr[2:0] zeroed).
- mem_wen  output  1  request is a write.
- mem_wdata  output  XLEN  lane-shifted store data.
- mem_wmask  output  8  byte-write mask.
- mem_rsp_valid  input  1  response/data valid.
- mem_rdata  input  XLEN  read data (8-byte aligned word).
- rf_we  output  1  register file write enable, one-cycle pulse.
- rf_waddr  output  5  register file write address.
- rf_wdata  output  XLEN  register file write data.
- wb_done  output  1  one-cycle pulse per completed op.
- misalign_err  output  1  one-cycle pulse, misaligned access dropped.

Behaviour:
- Reset: state=IDLE; ex_ready=1 (combinational from IDLE). All of the following are 0: mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, rf_we, rf_waddr, rf_wdata, wb_done, misalign_err.
- States and transitions:
  - IDLE: ex_ready=1. On ex_valid, latch all ex_* fields.
    - Misaligned load/store: go to WB with error.
    - Load or store: go to REQ.
    - Otherwise: go to WB.
  - REQ: mem_req_valid=1. mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready=1, then go to WAIT.
  - WAIT: mem_req_valid=0. mem_rsp_valid is ignored in the acceptance cycle. On mem_rsp_valid go to WB, capturing mem_rdata.
  - WB: for one cycle, wb_done=1 and rf_we=latched reg_we & (rd!=0) & !error. The WB-cycle signals are registered outputs. Next state is IDLE.
- ex_ready is 0 in REQ, WAIT and WB; at most one op is in flight.
- Size by funct3:
  - 000 LB/SB = 1 byte.
  - 001 LH/SH = 2 bytes.
  - 010 LW/SW = 4 bytes.
  - 011 LD/SD = 8 bytes.
  - 100 LBU, 101 LHU, 110 LWU.
  - 111 is treated as misaligned/illegal.
- Misaligned: addr[0]!=0 for 2-byte, addr[1:0]!=0 for 4-byte, addr[2:0]!=0 for 8-byte. No bus request is issued; misalign_err=1 and wb_done=1 in WB; rf_we=0.
- Store lanes: off=addr[2:0].
  - mem_wmask = {01,03,0F,FF} << off.
  - mem_wdata = store_data << (8*off).
  - mem_wen=1.
- Load extraction: (mem_rdata >> 8*off), truncated to size.
  - Sign-extended for LB/LH/LW; zero-extended for LBU/LHU/LWU.
  - LD is unchanged.
- rf_wdata = extracted load data for loads, alu_result otherwise. rf_waddr = latched rd.
- Stores never write the register file.
- Latency:
  - ALU op accepted at cycle N: rf_we=1 at N+1; ex_ready=1 again at N+2.
  - Load with ready and response at the earliest: accept N, mem_req_valid N+1 (ready), rsp N+2, rf_we N+3.
- mem_rsp_valid arriving in IDLE, REQ or WB is ignored.
- Reset in any state abandons the op; an outstanding response after reset is ignored.

Test Plan:
- ALU op: ex_valid, alu_result=0x1234, rd=5, reg_we=1 at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 at N+1 only; wb_done=1 at N+1; ex_ready=0 at N+1.
- rd=0 ALU op -> wb_done=1, rf_we=0.
- LB at addr 0x1003 with mem_rdata=0x0000_0000_8000_0000 -> mem_addr=0x1000, rf_wdata=0xFFFF_FFFF_FFFF_FF80. LBU on the same data -> 0x80.
- SH at addr 0x2006, store_data=0xABCD, mem_req_ready held 0 for 3 cycles -> mem_req_valid, addr, data and mask stable throughout; mem_wmask=0xC0, mem_wdata=0xABCD<<48; after response, wb_done=1 and rf_we=0.
- LW at addr 0x1002 -> no mem_req_valid ever; misalign_err=1 and wb_done=1 one cycle after accept; rf_we=0.
- Load in WAIT, rst=1 for one cycle, mem_rsp_valid arrives after reset -> all outputs 0 and ex_ready=1 after reset; no rf_we from the stale response.
